// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wb_arbiter_if : writeback requester and regfile write bundle  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [31:0]       busy;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  a_ready, b_ready, RegWrite, WriteRegister, WriteData, busy
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output a_ready, b_ready, RegWrite, WriteRegister, WriteData, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wb_arbiter : two-requester round-robin regfile write arbiter |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_wb_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  wire logic            clk,
    input  wire logic            reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic              held_a, held_b;
    logic [ADDR_W-1:0] hreg_a, hreg_b;
    logic [DATA_W-1:0] hdata_a, hdata_b;
    logic              ptr_b;
    logic              a_older;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;

    logic keep_a, keep_b;
    logic same_reg, forced;
    logic gnt_a, gnt_b;

    assign bus.a_ready       = ~held_a;
    assign bus.b_ready       = ~held_b;
    assign bus.RegWrite      = reg_write;
    assign bus.WriteRegister = write_reg;
    assign bus.WriteData     = write_data;

    // Writes to the hard-zero register complete the handshake but are dropped.
    assign keep_a = bus.a_valid & ~held_a & (bus.a_reg != ZERO_IDX);
    assign keep_b = bus.b_valid & ~held_b & (bus.b_reg != ZERO_IDX);

    assign same_reg = (hreg_a == hreg_b);
    assign forced   = held_a & held_b & same_reg;
    assign gnt_a    = held_a & (~held_b | (same_reg ? a_older : ~ptr_b));
    assign gnt_b    = held_b & ~gnt_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_a     <= 1'b0;
            held_b     <= 1'b0;
            hreg_a     <= '0;
            hreg_b     <= '0;
            hdata_a    <= '0;
            hdata_b    <= '0;
            ptr_b      <= 1'b0;
            a_older    <= 1'b0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            held_a <= keep_a | (held_a & ~gnt_a);
            held_b <= keep_b | (held_b & ~gnt_b);
            if (keep_a) begin
                hreg_a  <= bus.a_reg;
                hdata_a <= bus.a_data;
            end
            if (keep_b) begin
                hreg_b  <= bus.b_reg;
                hdata_b <= bus.b_data;
            end
            // A newcomer is always younger than an entry already waiting;
            // on a same-cycle double accept B counts as older.
            if (keep_b && !keep_a) begin
                a_older <= 1'b1;
            end else if (keep_a) begin
                a_older <= 1'b0;
            end
            // Every round-robin grant hands priority to the other side.
            if (!forced) begin
                if (gnt_a) begin
                    ptr_b <= 1'b1;
                end else if (gnt_b) begin
                    ptr_b <= 1'b0;
                end
            end
            reg_write <= gnt_a | gnt_b;
            if (gnt_a) begin
                write_reg  <= hreg_a;
                write_data <= hdata_a;
            end else if (gnt_b) begin
                write_reg  <= hreg_b;
                write_data <= hdata_b;
            end
        end
    end

    always_comb begin
        bus.busy = '0;
        for (int i = 0; i < 32; i++) begin
            bus.busy[i] = (held_a & (hreg_a == ADDR_W'(i))) |
                          (held_b & (hreg_b == ADDR_W'(i))) |
                          (reg_write & (write_reg == ADDR_W'(i)));
        end
        bus.busy[ZERO_REG] = 1'b0;
    end
endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite / WriteRegister / WriteData) between two writeback requesters.
  - Requester A: ALU writeback.
  - Requester B: load writeback.
- Each requester has a one-entry holding register. Arbitration is round-robin with same-register ordering protection.
- Publishes a per-register busy vector so the hazard unit can stall reads of registers with a write in flight.
- Sits between the EX/MEM writeback stages and regfile; drives its write port directly.

Parameters:
- DATA_W, 64, write data width.
- ADDR_W, 5, register index width.
- ZERO_REG, 31, hard-zero register index; writes to it are discarded.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A holding register empty; transfer when a_valid && a_ready.
- a_reg  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B holding register empty.
- b_reg  in  ADDR_W  B destination register.
- b_data  in  DATA_W  B write data.
- RegWrite  out  1  registered write enable to regfile.
- WriteRegister  out  ADDR_W  registered write index.
- WriteData  out  DATA_W  registered write data.
- busy  out  32  busy[r]=1 while a write to r is held or on the output stage; busy[ZERO_REG] always 0.

Behaviour:
- Reset (async assert, sync release):
  - Both holding registers empty.
  - RegWrite=0, WriteRegister=0, WriteData=0, busy=0.
  - Round-robin pointer = A; age bit cleared.
  - Reset mid-operation discards all held and staged writes; nothing reaches regfile after reset asserts.
- Ready and accept:
  - a_ready = ~heldA; b_ready = ~heldB (no combinational path from valid).
  - On accept, reg and data are captured into the holding register.
- ZERO_REG:
  - A transfer with reg==ZERO_REG completes the handshake but is not held.
  - It never produces RegWrite=1 and never sets busy.
- Grant (evaluated each cycle over held entries):
  - Only one held: grant it.
  - Both held, different regs: grant pointer side; pointer then flips to the other side.
  - Both held, same reg: grant the older entry (age bit). If both were accepted in the same cycle, B is older and goes first. Pointer is unchanged by an order-forced grant.
  - Granted entry is copied to the output stage (RegWrite=1, WriteRegister, WriteData) at the next posedge; its holding register empties at that same edge.
- Output stage:
  - RegWrite is high for exactly one cycle per granted write.
  - RegWrite is 0 on any cycle with no grant; WriteRegister/WriteData hold their last values.
  - Regfile commits on the edge after RegWrite rises.
- Latency: accept at edge N, RegWrite=1 during cycle N+1..N+2, regfile updated at edge N+2. The losing side waits one extra cycle per lost grant.
- Throughput: one write per cycle. A side may re-accept in the cycle after its entry is granted, so the sustained per-side rate is 1 write / 2 cycles.
- Busy:
  - busy = OR of decoded held regs and decoded output-stage reg (when RegWrite=1), with ZERO_REG masked.
  - Combinational from state only.
- Starvation bound: a held entry is granted within 2 cycles.

Test Plan:
- Reset: hold reset=0 with a_valid=b_valid=1 -> a_ready=b_ready=0 is not required; RegWrite=0, busy=0. Release reset, then assert a_valid=1, a_reg=3, a_data=64'h5 -> exactly one RegWrite pulse with WriteRegister=3, WriteData=5, two edges after accept; busy[3] high for exactly those two cycles.
- Zero register: a_reg=31, a_data=64'hA0, a_valid=1 for 1 cycle -> handshake completes; RegWrite stays 0; busy stays 0.
- Contention, different regs: A(reg 4, data 1) and B(reg 5, data 2) accepted in the same cycle -> B written first (same-cycle age rule does not apply), then A on the next cycle. Repeat continuously -> grants alternate A/B with no gaps.
- Same-register ordering: B(reg 7, 64'h11) and A(reg 7, 64'h22) accepted in the same cycle -> WriteData order 11 then 22; final regfile X7 = 64'h22.
- Backpressure: a_valid held high with 10 back-to-back writes while B is also saturated -> a_ready toggles 1/0; all 20 writes appear exactly once, in per-side order.
- Reset mid-operation: both entries held, then reset=0 for 1 cycle -> no RegWrite pulse afterwards; busy=0; ready=1 after release.
